// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback-side bus of the multi-port register file.
// Carries read ports, both write ports, busy allocation and the busy count.
// The master drives addresses, writes and allocation; the slave (the register
// file) returns read data, per-port busy bits and the busy count.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  we0;
    logic                  we1;
    logic [ADDR_W-1:0]     wa0;
    logic [ADDR_W-1:0]     wa1;
    logic [DATA_W-1:0]     wd0;
    logic [DATA_W-1:0]     wd1;
    logic                  wclr0;
    logic                  wclr1;
    logic                  alloc;
    logic [ADDR_W-1:0]     alloc_addr;
    logic [ADDR_W:0]       busy_cnt;

    modport master (
        output rd_addr, we0, we1, wa0, wa1, wd0, wd1, wclr0, wclr1, alloc, alloc_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, wclr0, wclr1, alloc, alloc_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2^ADDR_W x DATA_W register file with NRD combinational read
// ports, two synchronous write ports, hardwired-zero entry 0 and a per-entry
// busy scoreboard with a registered popcount.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through on
// the read ports; without it reads return stored state only.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_next;
    logic [DEPTH-1:0]  wr0_hit;
    logic [DEPTH-1:0]  wr1_hit;
    logic [DEPTH-1:0]  clr_hit;
    logic [DEPTH-1:0]  alloc_hit;
    logic [ADDR_W-1:0] ra [NRD];

    // Decode write and allocation ports into per-entry hit vectors; entry 0 never hits.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it holding a value (no latch).
        wr0_hit   = '0;
        wr1_hit   = '0;
        alloc_hit = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr0_hit[i]   = bus.we0 && (bus.wa0 == ADDR_W'(i));
            wr1_hit[i]   = bus.we1 && (bus.wa1 == ADDR_W'(i));
            alloc_hit[i] = bus.alloc && (bus.alloc_addr == ADDR_W'(i));
        end
        // Clear requests from both ports are OR'd, including on a same-address collision.
        clr_hit = (wr0_hit & {DEPTH{bus.wclr0}}) | (wr1_hit & {DEPTH{bus.wclr1}});
    end

    // Next scoreboard state and its popcount; a new producer wins over a same-cycle release.
    always_comb begin
        busy_next     = alloc_hit | (busy & ~clr_hit);
        busy_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // NOTE: blocking assignment is intended here: each iteration must see the running sum of the previous one.
            busy_cnt_next = busy_cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Entry storage; port 1 is checked first so it owns a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose: every entry must read zero straight after reset, so this cannot map to a reset-less RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
                if (wr1_hit[i]) begin
                    mem[i] <= bus.wd1;
                end else if (wr0_hit[i]) begin
                    mem[i] <= bus.wd0;
                end
            end
        end
    end

    // Scoreboard bits and their count update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_next;
            busy_cnt_q <= busy_cnt_next;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

    // Read ports: entry 0 reads as zero and never busy; optional same-cycle write-through.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (ra[k] != '0) begin
                bus.rd_data[k*DATA_W +: DATA_W] = mem[ra[k]];
                bus.rd_busy[k]                  = busy[ra[k]];
`ifdef REGFILE_BYPASS_EN
                if (bus.we1 && (bus.wa1 == ra[k])) begin
                    bus.rd_data[k*DATA_W +: DATA_W] = bus.wd1;
                end else if (bus.we0 && (bus.wa0 == ra[k])) begin
                    bus.rd_data[k*DATA_W +: DATA_W] = bus.wd0;
                end
                if ((bus.we0 && bus.wclr0 && (bus.wa0 == ra[k])) ||
                    (bus.we1 && bus.wclr1 && (bus.wa1 == ra[k]))) begin
                    bus.rd_busy[k] = 1'b0;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp. Directed scenarios plus a
// randomized run checked against an array-based reference model of the
// register file and its busy scoreboard. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: architectural contents and busy flags after the last edge.
    logic [DATA_W-1:0] model_mem  [DEPTH];
    bit                model_busy [DEPTH];

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_busy[i] = 1'b0;
        end
    endfunction

    // Effect of one rising edge: writes in port order (port 1 last, so it wins),
    // then releases, then allocation (a new producer overrides a release).
    function automatic void model_edge();
        if (bus.we0 && bus.wa0 != 0) model_mem[bus.wa0] = bus.wd0;
        if (bus.we1 && bus.wa1 != 0) model_mem[bus.wa1] = bus.wd1;
        if (bus.we0 && bus.wclr0) model_busy[bus.wa0] = 1'b0;
        if (bus.we1 && bus.wclr1) model_busy[bus.wa1] = 1'b0;
        if (bus.alloc) model_busy[bus.alloc_addr] = 1'b1;
        model_busy[0] = 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we1 && bus.wa1 == a) return bus.wd1;
        if (bus.we0 && bus.wa0 == a) return bus.wd0;
`endif
        return model_mem[a];
    endfunction

    function automatic logic exp_busy(logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((bus.we0 && bus.wclr0 && bus.wa0 == a) || (bus.we1 && bus.wclr1 && bus.wa1 == a))
            return 1'b0;
`endif
        return model_busy[a];
    endfunction

    function automatic logic [ADDR_W:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(model_busy[i]);
        return (ADDR_W+1)'(n);
    endfunction

    function automatic logic [DATA_W-1:0] rd_data_of(int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_rd(int k, logic [ADDR_W-1:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic idle();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.wa0 = '0;   bus.wa1 = '0;
        bus.wd0 = '0;   bus.wd1 = '0;
        bus.wclr0 = 1'b0; bus.wclr1 = 1'b0;
        bus.alloc = 1'b0; bus.alloc_addr = '0;
    endtask

    task automatic rand_inputs(int span);
        for (int k = 0; k < NRD; k++) set_rd(k, ADDR_W'($urandom_range(0, span)));
        bus.we0 = 1'($urandom);   bus.we1 = 1'($urandom);
        bus.wa0 = ADDR_W'($urandom_range(0, span));
        bus.wa1 = ADDR_W'($urandom_range(0, span));
        bus.wd0 = $urandom;       bus.wd1 = $urandom;
        bus.wclr0 = 1'($urandom); bus.wclr1 = 1'($urandom);
        bus.alloc = 1'($urandom);
        bus.alloc_addr = ADDR_W'($urandom_range(0, span));
    endtask

    // Apply current inputs across one rising edge and settle just after it.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rd_addr = '0;
        #1 rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            rand_inputs(DEPTH - 1);
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (rd_data_of(k) !== '0 || bus.rd_busy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_outputs port%0d: got data=%h busy=%b, need 0/0", k, rd_data_of(k), bus.rd_busy[k]);
                end
            end
            vectors++;
            if (bus.busy_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_busy_cnt: got %0d, need 0", bus.busy_cnt);
            end
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, ADDR_W'(a));
            set_rd(1, ADDR_W'(DEPTH - 1 - a));
            #1;
            vectors++;
            if (bus.rd_data !== '0 || bus.rd_busy !== '0) begin
                miscompares++;
                $display("FAIL post_reset_read addr%0d: got data=%h busy=%b, need 0", a, bus.rd_data, bus.rd_busy);
            end
        end
    endtask

    task automatic test_zero_register();
        idle();
        set_rd(0, '0);
        bus.we0 = 1'b1; bus.wa0 = '0; bus.wd0 = 32'hDEADBEEF;
        bus.alloc = 1'b1; bus.alloc_addr = '0;
        #1;
        vectors++;
        if (rd_data_of(0) !== '0) begin
            miscompares++;
            $display("FAIL zero_same_cycle: got %h, need 0", rd_data_of(0));
        end
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_data_of(0) !== '0 || bus.rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after_write: got data=%h busy=%b, need 0/0", rd_data_of(0), bus.rd_busy[0]);
        end
        vectors++;
        if (bus.busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL zero_busy_cnt: got %0d, need 0", bus.busy_cnt);
        end
    endtask

    task automatic test_collision();
        idle();
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h11111111;
        bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h22222222;
        cycle();
        idle();
        set_rd(0, 5'd5);
        #1;
        vectors++;
        if (rd_data_of(0) !== 32'h22222222) begin
            miscompares++;
            $display("FAIL collision_data: got %h, need 22222222", rd_data_of(0));
        end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.alloc = 1'b1; bus.alloc_addr = 5'd7;
        cycle();
        idle();
        set_rd(0, 5'd7);
        #1;
        vectors++;
        if (bus.rd_busy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL alloc_7: got busy=%b cnt=%0d, need 1/1", bus.rd_busy[0], bus.busy_cnt);
        end
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wclr1 = 1'b1; bus.wd1 = 32'h00001234;
        cycle();
        idle();
        #1;
        vectors++;
        if (bus.rd_busy[0] !== 1'b0 || bus.busy_cnt !== 6'd0 || rd_data_of(0) !== 32'h00001234) begin
            miscompares++;
            $display("FAIL clear_7: got busy=%b cnt=%0d data=%h, need 0/0/00001234", bus.rd_busy[0], bus.busy_cnt, rd_data_of(0));
        end
        bus.alloc = 1'b1; bus.alloc_addr = 5'd9;
        bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wclr0 = 1'b1; bus.wd0 = $urandom;
        cycle();
        idle();
        set_rd(0, 5'd9);
        #1;
        vectors++;
        if (bus.rd_busy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL alloc_clear_9: got busy=%b cnt=%0d, need 1/1", bus.rd_busy[0], bus.busy_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] same_cycle;
        idle();
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h0BADF00D;
        cycle();
        idle();
        set_rd(1, 5'd3);
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hCAFE0001;
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'hCAFE0001;
`else
        same_cycle = 32'h0BADF00D;
`endif
        #1;
        vectors++;
        if (rd_data_of(1) !== same_cycle) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h, need %h", rd_data_of(1), same_cycle);
        end
        cycle();
        idle();
        #1;
        vectors++;
        if (rd_data_of(1) !== 32'hCAFE0001) begin
            miscompares++;
            $display("FAIL bypass_next_cycle: got %h, need cafe0001", rd_data_of(1));
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        for (int n = 0; n < 400; n++) begin
            rand_inputs((n % 2 == 1) ? 7 : DEPTH - 1);
            #1;
            for (int k = 0; k < NRD; k++) begin
                a = bus.rd_addr[k*ADDR_W +: ADDR_W];
                vectors++;
                if (rd_data_of(k) !== exp_data(a)) begin
                    miscompares++;
                    $display("FAIL random_data n%0d port%0d addr%0d: got %h, need %h", n, k, a, rd_data_of(k), exp_data(a));
                end
                vectors++;
                if (bus.rd_busy[k] !== exp_busy(a)) begin
                    miscompares++;
                    $display("FAIL random_busy n%0d port%0d addr%0d: got %b, need %b", n, k, a, bus.rd_busy[k], exp_busy(a));
                end
            end
            vectors++;
            if (bus.busy_cnt !== exp_cnt()) begin
                miscompares++;
                $display("FAIL random_busy_cnt n%0d: got %0d, need %0d", n, bus.busy_cnt, exp_cnt());
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid_op();
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        model_clear();
        for (int i = 1; i <= 10; i++) begin
            bus.we0 = 1'b1; bus.wa0 = ADDR_W'(i); bus.wd0 = $urandom | 32'h1;
            bus.alloc = 1'b1; bus.alloc_addr = ADDR_W'(i);
            cycle();
        end
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        vectors++;
        if (bus.busy_cnt !== 6'd10 || rd_data_of(0) !== model_mem[1]) begin
            miscompares++;
            $display("FAIL pre_reset_state: got cnt=%0d data=%h, need 10/%h", bus.busy_cnt, rd_data_of(0), model_mem[1]);
        end
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hFFFFFFFF;
        bus.alloc = 1'b1; bus.alloc_addr = 5'd12;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_immediate: got data=%h busy=%b cnt=%0d, need 0", bus.rd_data, bus.rd_busy, bus.busy_cnt);
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        model_clear();
        set_rd(0, 5'd3);
        set_rd(1, 5'd12);
        cycle();
        vectors++;
        if (rd_data_of(0) !== '0 || bus.rd_busy !== '0 || bus.busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL write_lost_in_reset: got data=%h busy=%b cnt=%0d, need 0", rd_data_of(0), bus.rd_busy, bus.busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_zero_register();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
